// File: rtl/simon_pkg.sv
// simon_pkg: shared state encoding and field widths for the Sly Man Says sequencer.
package simon_pkg;
    localparam int COLOR_W = 2;
    localparam int LEVEL_W = 7;
    typedef enum logic [2:0] {
        IDLE, EXTEND, SHOW_ON, SHOW_GAP, WAIT_INPUT, PASS, FAIL, WON
    } seq_state_t;
endpackage

// File: rtl/simon_sequencer_phase_timer.sv
// phase_timer: loadable down-counter; done is high while the count sits at 1.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        if (reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - W'(1);
    assign done = cnt == W'(1);
endmodule

// File: rtl/simon_sequencer.sv
// simon_sequencer: grows, plays back and checks the Simon color pattern.
// Define SEQ_NO_REPEAT_EN to force adjacent pattern colors to differ.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int MAX_LEN     = 32,
    parameter int SHOW_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 5_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        random_num,
    input  logic               start,
    input  logic               btn_valid,
    input  logic [COLOR_W-1:0] btn_color,
    output logic               led_valid,
    output logic [COLOR_W-1:0] led_color,
    output logic               await_input,
    output logic               round_pass,
    output logic               game_over,
    output logic               game_won,
    output logic [LEVEL_W-1:0] level
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2((SHOW_CYCLES > GAP_CYCLES ? SHOW_CYCLES : GAP_CYCLES) + 1);
    seq_state_t state, state_n;
    logic [LEVEL_W-1:0] len, len_n, idx, idx_n;
    logic [COLOR_W-1:0] pattern [MAX_LEN];
    logic [COLOR_W-1:0] wr_color, shown;
    logic load, done, last;
    logic unused_rnd;
    assign unused_rnd = ^random_num[31:COLOR_W];
`ifdef SEQ_NO_REPEAT_EN
    logic [LEVEL_W-1:0] prev;
    assign prev = len - LEVEL_W'(1);
    assign wr_color = (len != '0 && random_num[COLOR_W-1:0] == pattern[prev[AW-1:0]])
                    ? random_num[COLOR_W-1:0] + COLOR_W'(1) : random_num[COLOR_W-1:0];
`else
    assign wr_color = random_num[COLOR_W-1:0];
`endif
    assign last = idx == len - LEVEL_W'(1);
    always_comb begin
        state_n = state;
        len_n = len;
        idx_n = idx;
        case (state)
            IDLE: if (start) begin
                state_n = EXTEND;
                len_n = '0;
            end
            EXTEND: begin
                state_n = SHOW_ON;
                len_n = len + LEVEL_W'(1);
                idx_n = '0;
            end
            SHOW_ON: if (done) state_n = SHOW_GAP;
            SHOW_GAP: if (done) begin
                state_n = last ? WAIT_INPUT : SHOW_ON;
                idx_n = last ? '0 : idx + LEVEL_W'(1);
            end
            WAIT_INPUT: if (btn_valid) begin
                if (btn_color != pattern[idx[AW-1:0]]) state_n = FAIL;
                else if (!last) idx_n = idx + LEVEL_W'(1);
                else state_n = (len == LEVEL_W'(MAX_LEN)) ? WON : PASS;
            end
            PASS: state_n = EXTEND;
            default: state_n = IDLE;
        endcase
    end
    // The timer reloads on every entry into a lit or dark phase.
    assign load = (state_n == SHOW_ON || state_n == SHOW_GAP) && state_n != state;
    // Entering the first show of round one reads the entry being written this edge.
    assign shown = (state == EXTEND && len == '0) ? wr_color : pattern[idx_n[AW-1:0]];
    phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (state_n == SHOW_ON ? TW'(SHOW_CYCLES) : TW'(GAP_CYCLES)),
        .done     (done)
    );
    always_ff @(posedge clk)
        if (state == EXTEND) pattern[len[AW-1:0]] <= wr_color;
    always_ff @(posedge clk)
        if (reset) begin
            state       <= IDLE;
            len         <= '0;
            idx         <= '0;
            led_valid   <= 1'b0;
            led_color   <= '0;
            await_input <= 1'b0;
            round_pass  <= 1'b0;
            game_over   <= 1'b0;
            game_won    <= 1'b0;
        end else begin
            state       <= state_n;
            len         <= len_n;
            idx         <= idx_n;
            led_valid   <= state_n == SHOW_ON;
            led_color   <= state_n == SHOW_ON ? shown : '0;
            await_input <= state_n == WAIT_INPUT;
            round_pass  <= state_n == PASS;
            game_over   <= state_n == FAIL;
            game_won    <= state_n == WON;
        end
    assign level = len;
endmodule

// File: tb/tb_simon_sequencer.sv
// tb_simon_sequencer: directed checks of pattern growth, playback, input checking and win/fail.
module tb_simon_sequencer;
    localparam int MAX_LEN = 3;
    localparam int SHOW = 4;
    localparam int GAP = 2;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic btn_valid = 1'b0;
    logic [1:0] btn_color = 2'd0;
    logic [31:0] random_num = 32'd0;
    logic led_valid, await_input, round_pass, game_over, game_won;
    logic [1:0] led_color;
    logic [6:0] level;
    logic [12:0] outs;
    logic [1:0] exp2;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simon_sequencer #(.MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP)) dut (
        .clk         (clk),
        .reset       (reset),
        .random_num  (random_num),
        .start       (start),
        .btn_valid   (btn_valid),
        .btn_color   (btn_color),
        .led_valid   (led_valid),
        .led_color   (led_color),
        .await_input (await_input),
        .round_pass  (round_pass),
        .game_over   (game_over),
        .game_won    (game_won),
        .level       (level)
    );
    assign outs = {led_valid, led_color, await_input, round_pass, game_over, game_won, level};

    task automatic step();
        @(negedge clk);
    endtask

    task automatic press(input logic [1:0] c);
        btn_valid = 1'b1;
        btn_color = c;
        step();
        btn_valid = 1'b0;
    endtask

    // Called in the EXTEND cycle; follows n colors of playback up to await_input.
    task automatic expect_playback(input logic [5:0] colors, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < SHOW; i++) begin
                step();
                checks++;
                if (led_valid !== 1'b1 || led_color !== colors[2*k +: 2]) begin
                    failures++;
                    $display("FAIL show k=%0d i=%0d: got valid=%b color=%0d, want valid=1 color=%0d",
                             k, i, led_valid, led_color, colors[2*k +: 2]);
                end
            end
            for (int i = 0; i < GAP; i++) begin
                step();
                checks++;
                if ({led_valid, led_color, await_input} !== 4'b0) begin
                    failures++;
                    $display("FAIL gap k=%0d i=%0d: got valid=%b color=%0d await=%b, want all 0",
                             k, i, led_valid, led_color, await_input);
                end
            end
        end
        step();
        checks++;
        if (await_input !== 1'b1 || led_valid !== 1'b0) begin
            failures++;
            $display("FAIL await_rise: got await=%b valid=%b, want 1/0", await_input, led_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (outs !== 13'd0) begin
            failures++;
            $display("FAIL reset_held: got %h, want 0", outs);
        end
        reset = 1'b0;
        step();
        checks++;
        if (outs !== 13'd0) begin
            failures++;
            $display("FAIL reset_idle: got %h, want 0", outs);
        end
    endtask

    task automatic test_round1();
        random_num = 32'h2;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (led_valid !== 1'b0 || level !== 7'd0) begin
            failures++;
            $display("FAIL extend1: got valid=%b level=%0d, want 0/0", led_valid, level);
        end
        expect_playback(6'b00_00_10, 1);
        checks++;
        if (level !== 7'd1) begin
            failures++;
            $display("FAIL level1: got %0d, want 1", level);
        end
        random_num = 32'h1;
        press(2'd2);
        checks++;
        if (round_pass !== 1'b1 || game_over !== 1'b0 || await_input !== 1'b0) begin
            failures++;
            $display("FAIL pass1: got pass=%b over=%b await=%b, want 1/0/0", round_pass, game_over, await_input);
        end
        step();
        checks++;
        if (round_pass !== 1'b0 || led_valid !== 1'b0) begin
            failures++;
            $display("FAIL pass1_pulse: got pass=%b valid=%b, want 0/0", round_pass, led_valid);
        end
        expect_playback(6'b00_01_10, 2);
        checks++;
        if (level !== 7'd2) begin
            failures++;
            $display("FAIL level2: got %0d, want 2", level);
        end
    endtask

    task automatic test_fail();
        press(2'd2);
        checks++;
        if (await_input !== 1'b1 || round_pass !== 1'b0 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL mid_press: got await=%b pass=%b over=%b, want 1/0/0", await_input, round_pass, game_over);
        end
        press(2'd3);
        checks++;
        if (game_over !== 1'b1 || await_input !== 1'b0) begin
            failures++;
            $display("FAIL game_over: got over=%b await=%b, want 1/0", game_over, await_input);
        end
        step();
        checks++;
        if (game_over !== 1'b0 || level !== 7'd2) begin
            failures++;
            $display("FAIL over_pulse: got over=%b level=%0d, want 0/2", game_over, level);
        end
        repeat (3) step();
        checks++;
        if (led_valid !== 1'b0 || await_input !== 1'b0 || level !== 7'd2) begin
            failures++;
            $display("FAIL idle_hold: got valid=%b await=%b level=%0d, want 0/0/2", led_valid, await_input, level);
        end
    endtask

    task automatic test_no_repeat();
`ifdef SEQ_NO_REPEAT_EN
        exp2 = 2'd2;
`else
        exp2 = 2'd1;
`endif
        random_num = 32'h1;
        start = 1'b1;
        btn_valid = 1'b1;
        btn_color = 2'd0;
        step();
        start = 1'b0;
        btn_valid = 1'b0;
        checks++;
        if (level !== 7'd0 || await_input !== 1'b0 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL start_press: got level=%0d await=%b over=%b, want 0/0/0", level, await_input, game_over);
        end
        expect_playback(6'b00_00_01, 1);
        press(2'd1);
        checks++;
        if (round_pass !== 1'b1) begin
            failures++;
            $display("FAIL pass_nr: got %b, want 1", round_pass);
        end
        step();
        expect_playback({2'b00, exp2, 2'b01}, 2);
    endtask

    task automatic test_won();
        random_num = 32'h3;
        press(2'd1);
        press(exp2);
        checks++;
        if (round_pass !== 1'b1 || game_won !== 1'b0) begin
            failures++;
            $display("FAIL pass2: got pass=%b won=%b, want 1/0", round_pass, game_won);
        end
        step();
        expect_playback({2'b11, exp2, 2'b01}, 3);
        press(2'd1);
        press(exp2);
        checks++;
        if (await_input !== 1'b1 || round_pass !== 1'b0 || game_won !== 1'b0) begin
            failures++;
            $display("FAIL won_mid: got await=%b pass=%b won=%b, want 1/0/0", await_input, round_pass, game_won);
        end
        press(2'd3);
        checks++;
        if (game_won !== 1'b1 || round_pass !== 1'b0 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL game_won: got won=%b pass=%b over=%b, want 1/0/0", game_won, round_pass, game_over);
        end
        step();
        checks++;
        if (game_won !== 1'b0 || level !== 7'd3 || await_input !== 1'b0 || led_valid !== 1'b0) begin
            failures++;
            $display("FAIL won_idle: got won=%b level=%0d await=%b valid=%b, want 0/3/0/0",
                     game_won, level, await_input, led_valid);
        end
    endtask

    task automatic test_ignore_and_reset();
        random_num = 32'h0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (led_valid !== 1'b1 || led_color !== 2'd0) begin
            failures++;
            $display("FAIL show_ig: got valid=%b color=%0d, want 1/0", led_valid, led_color);
        end
        btn_valid = 1'b1;
        btn_color = 2'd3;
        start = 1'b1;
        step();
        btn_valid = 1'b0;
        start = 1'b0;
        checks++;
        if (led_valid !== 1'b1 || led_color !== 2'd0 || level !== 7'd1 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL ignore: got valid=%b color=%0d level=%0d over=%b, want 1/0/1/0",
                     led_valid, led_color, level, game_over);
        end
        repeat (3) step();
        checks++;
        if (led_valid !== 1'b0 || await_input !== 1'b0 || level !== 7'd1) begin
            failures++;
            $display("FAIL gap_ig: got valid=%b await=%b level=%0d, want 0/0/1", led_valid, await_input, level);
        end
        reset = 1'b1;
        step();
        checks++;
        if (outs !== 13'd0) begin
            failures++;
            $display("FAIL reset_gap: got %h, want 0", outs);
        end
        reset = 1'b0;
        repeat (2) step();
        checks++;
        if (outs !== 13'd0) begin
            failures++;
            $display("FAIL post_reset: got %h, want 0", outs);
        end
    endtask

    initial begin
        test_reset();
        test_round1();
        test_fail();
        test_no_repeat();
        test_won();
        test_ignore_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
